// File: rtl/tick_divider_pkg.sv
// Shared constants and width helpers for the tick_divider timebase.
// Optional stage_cnt_o output is controlled by TICK_DIVIDER_CNT_OUT_EN.
package tick_divider_pkg;

  localparam int unsigned CNT_W_DEF = 24;
  localparam int unsigned DIV_DEF   = 2500000;
  localparam int unsigned RATIO_DEF = 10;

  // Smallest r with 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Stage counter width, never narrower than one bit.
  function automatic int unsigned stage_w(input int unsigned ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

  typedef logic [stage_w(RATIO_DEF)-1:0] stage_cnt_def_t;

endpackage

// File: rtl/tick_stage.sv
// One cascaded modulo-RATIO stage; carry_out_c fires when the carry reaches it at terminal count.
// The count port exists only with TICK_DIVIDER_CNT_OUT_EN defined.
module tick_stage
  import tick_divider_pkg::*;
#(
  parameter int unsigned RATIO = RATIO_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      carry_in,
  output logic                      carry_out_c
`ifdef TICK_DIVIDER_CNT_OUT_EN
  ,
  output logic [stage_w(RATIO)-1:0] count
`endif
);

  localparam int unsigned W = stage_w(RATIO);

  logic [W-1:0] count_q;
  logic         at_term_c;

  assign at_term_c   = (count_q == W'(RATIO - 1));
  assign carry_out_c = en && carry_in && at_term_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && carry_in) begin
      count_q <= at_term_c ? '0 : count_q + W'(1);
    end
  end

`ifdef TICK_DIVIDER_CNT_OUT_EN
  assign count = count_q;
`endif

endmodule

// File: rtl/tick_divider.sv
// Programmable prescaler plus cascaded decade-style stages producing single-cycle ticks and a square wave.
// Defining TICK_DIVIDER_CNT_OUT_EN adds stage_cnt_o with the live stage counts.
module tick_divider
  import tick_divider_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEF_DIV     = DIV_DEF,
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned STAGE_RATIO = RATIO_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic [CNT_W-1:0]       div_i,
  input  logic                   div_load,
  output logic                   div_busy,
  output logic [NUM_CH-1:0]      tick_o,
  output logic                   sq_o
`ifdef TICK_DIVIDER_CNT_OUT_EN
  ,
  output logic [(NUM_CH-1)*stage_w(STAGE_RATIO)-1:0] stage_cnt_o
`endif
);

`ifdef TICK_DIVIDER_CNT_OUT_EN
  localparam int unsigned SW = stage_w(STAGE_RATIO);
`endif

  logic [CNT_W-1:0]  div_act;
  logic [CNT_W-1:0]  div_pend;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  eff_div_c;
  logic              wrap_c;
  logic [NUM_CH-1:0] carry_c;

  // A zero divisor behaves as divide-by-one.
  assign eff_div_c  = (div_act == '0) ? CNT_W'(1) : div_act;
  assign wrap_c     = en && (cnt >= eff_div_c - CNT_W'(1));
  assign carry_c[0] = wrap_c;

  for (genvar k = 1; k < NUM_CH; k++) begin : g_stage
    tick_stage #(
      .RATIO(STAGE_RATIO)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clr        (clr),
      .carry_in   (carry_c[k-1]),
      .carry_out_c(carry_c[k])
`ifdef TICK_DIVIDER_CNT_OUT_EN
      ,
      .count      (stage_cnt_o[(k-1)*SW +: SW])
`endif
    );
  end

  // Prescaler, square wave, tick register and glitch-free divisor reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_act  <= CNT_W'(DEF_DIV);
      div_pend <= '0;
      div_busy <= 1'b0;
      cnt      <= '0;
      sq_o     <= 1'b0;
      tick_o   <= '0;
    end else if (clr) begin
      cnt      <= '0;
      sq_o     <= 1'b0;
      tick_o   <= '0;
      div_busy <= 1'b0;
      if (div_load) begin
        div_act <= div_i;
      end else if (div_busy) begin
        div_act <= div_pend;
      end
    end else if (!en) begin
      tick_o <= '0;
      if (div_load) begin
        div_act  <= div_i;
        cnt      <= '0;
        div_busy <= 1'b0;
      end
    end else begin
      tick_o <= carry_c;
      if (wrap_c) begin
        cnt  <= '0;
        sq_o <= ~sq_o;
        if (div_busy) begin
          div_act  <= div_pend;
          div_busy <= 1'b0;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // A load on a wrap edge stays pending for the following wrap.
      if (div_load) begin
        div_pend <= div_i;
        div_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tick_divider.sv
// Self-checking bench for tick_divider: directed table, corner sequences, randomized run vs. reference model.
module tb_tick_divider;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned DEF_DIV = 4;
  localparam int unsigned NUM_CH  = 3;
  localparam int unsigned RATIO   = 3;
  localparam int unsigned SW      = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic              div_load = 1'b0;
  logic [CNT_W-1:0]  div_i = '0;
  logic              div_busy;
  logic [NUM_CH-1:0] tick_o;
  logic              sq_o;
`ifdef TICK_DIVIDER_CNT_OUT_EN
  logic [(NUM_CH-1)*SW-1:0] stage_cnt_o;
`endif

  tick_divider #(
    .CNT_W      (CNT_W),
    .DEF_DIV    (DEF_DIV),
    .NUM_CH     (NUM_CH),
    .STAGE_RATIO(RATIO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (clr),
    .div_i   (div_i),
    .div_load(div_load),
    .div_busy(div_busy),
    .tick_o  (tick_o),
    .sq_o    (sq_o)
`ifdef TICK_DIVIDER_CNT_OUT_EN
    ,
    .stage_cnt_o(stage_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: period progress plus total wrap count since clear.
  int unsigned       m_act;
  int unsigned       m_pend;
  bit                m_busy;
  int unsigned       m_phase;
  longint            m_wraps;
  logic [NUM_CH-1:0] m_tick;

  typedef struct {
    bit          en;
    bit          ld;
    logic [7:0]  div;
    logic [2:0]  tick;
    bit          sq;
    bit          busy;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(bit e, bit l, logic [7:0] d, logic [2:0] t, bit s, bit b);
    vec_t v;
    v.en = e; v.ld = l; v.div = d; v.tick = t; v.sq = s; v.busy = b;
    return v;
  endfunction

  function automatic logic [NUM_CH-1:0] ticks_for(longint w);
    logic [NUM_CH-1:0] t;
    longint p;
    p = 1;
    t = '0;
    t[0] = 1'b1;
    for (int k = 1; k < NUM_CH; k++) begin
      p = p * RATIO;
      t[k] = ((w % p) == 0);
    end
    return t;
  endfunction

  task automatic model_reset();
    m_act = DEF_DIV; m_pend = 0; m_busy = 0; m_phase = 0; m_wraps = 0; m_tick = '0;
  endtask

  task automatic model_step(input bit e, input bit c, input bit l, input int unsigned d);
    int unsigned eff;
    if (c) begin
      m_phase = 0; m_wraps = 0; m_tick = '0;
      if (l) m_act = d;
      else if (m_busy) m_act = m_pend;
      m_busy = 0;
    end else if (!e) begin
      m_tick = '0;
      if (l) begin m_act = d; m_phase = 0; m_busy = 0; end
    end else begin
      eff = (m_act == 0) ? 1 : m_act;
      m_phase++;
      if (m_phase >= eff) begin
        m_phase = 0;
        m_wraps++;
        m_tick = ticks_for(m_wraps);
        if (m_busy) begin m_act = m_pend; m_busy = 0; end
      end else begin
        m_tick = '0;
      end
      if (l) begin m_pend = d; m_busy = 1; end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".tick"}, 64'(tick_o), 64'(m_tick));
    check({tag, ".sq"}, 64'(sq_o), 64'(m_wraps % 2));
    check({tag, ".busy"}, 64'(div_busy), 64'(m_busy));
`ifdef TICK_DIVIDER_CNT_OUT_EN
    begin
      logic [(NUM_CH-1)*SW-1:0] es;
      longint p;
      p = 1;
      es = '0;
      for (int k = 1; k < NUM_CH; k++) begin
        es[(k-1)*SW +: SW] = SW'((m_wraps / p) % RATIO);
        p = p * RATIO;
      end
      check({tag, ".stage_cnt"}, 64'(stage_cnt_o), 64'(es));
    end
`endif
  endtask

  // Apply inputs, clock one edge, advance the model, sample 1 time unit later.
  task automatic step(input bit e, input bit c, input bit l, input logic [CNT_W-1:0] d);
    en = e; clr = c; div_load = l; div_i = d;
    @(posedge clk);
    model_step(e, c, l, int'(d));
    #1;
  endtask

  initial begin
    // Default divisor 4, ratio 3: wraps at edges 4,8,12; div 6 loaded at edge 14 applies at edge 16.
    vecs[0]  = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[1]  = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[2]  = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[3]  = mk(1, 0, 8'd0, 3'b001, 1, 0);
    vecs[4]  = mk(1, 0, 8'd0, 3'b000, 1, 0);
    vecs[5]  = mk(1, 0, 8'd0, 3'b000, 1, 0);
    vecs[6]  = mk(1, 0, 8'd0, 3'b000, 1, 0);
    vecs[7]  = mk(1, 0, 8'd0, 3'b001, 0, 0);
    vecs[8]  = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[9]  = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[10] = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[11] = mk(1, 0, 8'd0, 3'b011, 1, 0);
    vecs[12] = mk(1, 0, 8'd0, 3'b000, 1, 0);
    vecs[13] = mk(1, 1, 8'd6, 3'b000, 1, 1);
    vecs[14] = mk(1, 0, 8'd0, 3'b000, 1, 1);
    vecs[15] = mk(1, 0, 8'd0, 3'b001, 0, 0);
    vecs[16] = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[17] = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[18] = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[19] = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[20] = mk(1, 0, 8'd0, 3'b000, 0, 0);
    vecs[21] = mk(1, 0, 8'd0, 3'b001, 1, 0);

    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset.tick", 64'(tick_o), 64'd0);
    check("reset.sq", 64'(sq_o), 64'd0);
    check("reset.busy", 64'(div_busy), 64'd0);

    for (int i = 0; i < 22; i++) begin
      step(vecs[i].en, 1'b0, vecs[i].ld, vecs[i].div);
      check($sformatf("vec%0d.tick", i), 64'(tick_o), 64'(vecs[i].tick));
      check($sformatf("vec%0d.sq", i), 64'(sq_o), 64'(vecs[i].sq));
      check($sformatf("vec%0d.busy", i), 64'(div_busy), 64'(vecs[i].busy));
    end

    // Divisor 0 behaves as 1: base tick held high, square wave toggles each cycle.
    step(1'b0, 1'b0, 1'b1, 8'd0);
    check_model("div0.load");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
      check($sformatf("div0.tick0_%0d", i), 64'(tick_o[0]), 64'd1);
      check_model($sformatf("div0_%0d", i));
    end

    // Hold mid-count: no ticks while disabled, then only the remaining count.
    step(1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 8'd4);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'd0);
      check($sformatf("hold.tick_%0d", i), 64'(tick_o), 64'd0);
    end
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("hold.resume3", 64'(tick_o), 64'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    check("hold.resume4", 64'(tick_o), 64'd1);
    check_model("hold");

    // Clear on a would-be wrap with a pending divisor of 7.
    step(1'b0, 1'b0, 1'b1, 8'd4);
    step(1'b1, 1'b0, 1'b1, 8'd7);
    check("clr.busy_set", 64'(div_busy), 64'd1);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b0, 8'd0);
    check("clr.tick", 64'(tick_o), 64'd0);
    check("clr.sq", 64'(sq_o), 64'd0);
    check("clr.busy", 64'(div_busy), 64'd0);
    for (int i = 1; i <= 7; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
      check($sformatf("clr.period7_%0d", i), 64'(tick_o[0]), (i == 7) ? 64'd1 : 64'd0);
      check_model($sformatf("clr_%0d", i));
    end

    // Asynchronous reset between clock edges.
    step(1'b0, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b0, 1'b1, 8'd4);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
    check("arst.pre_sq", 64'(sq_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.tick", 64'(tick_o), 64'd0);
    check("arst.sq", 64'(sq_o), 64'd0);
    check("arst.busy", 64'(div_busy), 64'd0);
    model_reset();
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full cascade after reset: all three ticks coincide on edge 36.
    for (int i = 1; i <= 36; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
      if (i <= 4) check($sformatf("arst.first_tick_%0d", i), 64'(tick_o[0]), (i == 4) ? 64'd1 : 64'd0);
      if (i == 12) check("casc.edge12", 64'(tick_o), 64'b011);
      if (i == 36) check("casc.edge36", 64'(tick_o), 64'b111);
      check_model($sformatf("casc_%0d", i));
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      bit e, c, l;
      logic [CNT_W-1:0] d;
      e = ($urandom_range(99) < 85);
      c = ($urandom_range(99) < 3);
      l = ($urandom_range(99) < 6);
      d = CNT_W'($urandom_range(7));
      step(e, c, l, d);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
